drum_step_sequencer: RTL and testbench

16-step, 4-voice drum pattern sequencer. Stores one 16-bit on/off pattern per voice (kick, snare, hat, chip) and steps through it at a fixed tempo, emitting single-cycle trigger pulses to the drum voice engines. The voice being edited comes from the one-hot kick/snare/hat/chip outputs of the drum sound selector. Pattern entry and play/stop come from active-low pushbuttons, using the same press-then-release action the sound selector uses.

---
 rtl/drum_step_sequencer.sv | 164 ++++++++++++++++
 tb/tb_drum_step_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_step_sequencer.sv
// rtl/drum_step_sequencer.sv - 16-step, 4-voice drum pattern sequencer with pushbutton edit and play/stop
module drum_step_sequencer #(
    parameter int STEP_TICKS = 6250000,
    parameter int STEPS      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  voice_sel,
    input  logic        play_key,
    input  logic        edit_key,
    input  logic [3:0]  cursor,
    output logic [3:0]  trig,
    output logic [3:0]  step,
    output logic        step_tick,
    output logic        running,
    output logic [15:0] pattern_view
);

    localparam int CW = $clog2(STEP_TICKS);
    localparam logic [CW-1:0] LAST_TICK = CW'(STEP_TICKS - 1);
    localparam logic [3:0]    LAST_STEP = 4'(STEPS - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   tick_cnt;
    logic [CW-1:0]   tick_nx;
    logic [3:0]      step_nx;
    logic [3:0]      trig_nx;
    logic            step_tick_nx;
    logic [3:0]      next_step;
    logic [3:0]      col_zero;
    logic [3:0]      col_next;

    logic            play_s1;
    logic            play_s2;
    logic            play_prev;
    logic            edit_s1;
    logic            edit_s2;
    logic            edit_prev;
    logic            play_rel;
    logic            edit_rel;

    // One 16-bit pattern per voice; pattern[v][s] is voice v at step s.
    logic [3:0][15:0] pattern;
    logic             edit_ok;
    logic [1:0]       edit_idx;

    // Two-flop synchronizers plus a previous-value register; idle level is 1 (released).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_s1   <= 1'b1;
            play_s2   <= 1'b1;
            play_prev <= 1'b1;
            edit_s1   <= 1'b1;
            edit_s2   <= 1'b1;
            edit_prev <= 1'b1;
        end else begin
            play_s1   <= play_key;
            play_s2   <= play_s1;
            play_prev <= play_s2;
            edit_s1   <= edit_key;
            edit_s2   <= edit_s1;
            edit_prev <= edit_s2;
        end
    end

    // Action happens on release (synchronized 0 -> 1), so holding a key is harmless.
    assign play_rel = play_s2 & ~play_prev;
    assign edit_rel = edit_s2 & ~edit_prev;

    // Lowest set bit of voice_sel picks the voice being edited.
    always_comb begin
        edit_idx = 2'd0;
        if (voice_sel[0])      edit_idx = 2'd0;
        else if (voice_sel[1]) edit_idx = 2'd1;
        else if (voice_sel[2]) edit_idx = 2'd2;
        else if (voice_sel[3]) edit_idx = 2'd3;
    end

    assign edit_ok      = |voice_sel;
    assign pattern_view = edit_ok ? pattern[edit_idx] : 16'h0000;

    // Edit toggles one pattern bit; trig logic below reads the pre-edit value on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= '0;
        end else if (edit_rel && edit_ok) begin
            pattern[edit_idx][cursor] <= ~pattern[edit_idx][cursor];
        end
    end

    assign next_step = (step == LAST_STEP) ? 4'd0 : step + 4'd1;

    // Trigger columns: all voices at step 0 (for start) and at the upcoming step.
    always_comb begin
        col_zero = 4'b0000;
        col_next = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            col_zero[v] = pattern[v][0];
            col_next[v] = pattern[v][next_step];
        end
    end

    // Next-state and next-output logic; trig/step_tick default to 0 so they are single-cycle pulses.
    always_comb begin
        state_nx     = state;
        tick_nx      = tick_cnt;
        step_nx      = step;
        trig_nx      = 4'b0000;
        step_tick_nx = 1'b0;
        unique case (state)
            STOP: begin
                if (play_rel) begin
                    state_nx     = RUN;
                    tick_nx      = '0;
                    step_nx      = 4'd0;
                    step_tick_nx = 1'b1;
                    trig_nx      = col_zero;
                end
            end
            RUN: begin
                if (play_rel) begin
                    // Stopping wins over a step boundary on the same edge.
                    state_nx = STOP;
                    tick_nx  = '0;
                    step_nx  = 4'd0;
                end else if (tick_cnt == LAST_TICK) begin
                    tick_nx      = '0;
                    step_nx      = next_step;
                    step_tick_nx = 1'b1;
                    trig_nx      = col_next;
                end else begin
                    tick_nx = tick_cnt + CW'(1);
                end
            end
            default: state_nx = STOP;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= STOP;
            tick_cnt  <= '0;
            step      <= 4'd0;
            trig      <= 4'b0000;
            step_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_nx;
            step      <= step_nx;
            trig      <= trig_nx;
            step_tick <= step_tick_nx;
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb/tb_drum_step_sequencer.sv - self-checking bench for drum_step_sequencer
module tb_drum_step_sequencer;

    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  voice_sel = 4'b0001;
    logic        play_key = 1'b1;
    logic        edit_key = 1'b1;
    logic [3:0]  cursor = 4'd0;
    logic [3:0]  trig;
    logic [3:0]  step;
    logic        step_tick;
    logic        running;
    logic [15:0] pattern_view;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] step;
        logic [3:0] trig;
    } ev_t;

    ev_t         q[$];
    logic [15:0] mpat [4];
    logic        mrun;
    logic [3:0]  mstep;

    drum_step_sequencer #(.STEP_TICKS(ST), .STEPS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .voice_sel    (voice_sel),
        .play_key     (play_key),
        .edit_key     (edit_key),
        .cursor       (cursor),
        .trig         (trig),
        .step         (step),
        .step_tick    (step_tick),
        .running      (running),
        .pattern_view (pattern_view)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col(input logic [3:0] s);
        logic [3:0] c;
        c = 4'b0000;
        for (int v = 0; v < 4; v++) c[v] = mpat[v][s];
        return c;
    endfunction

    task automatic push_exp(input logic [3:0] s);
        ev_t e;
        e.step = s;
        e.trig = col(s);
        q.push_back(e);
    endtask

    task automatic check_ev(input string tag);
        ev_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=no_event expected=queued_event", tag);
            return;
        end
        e = q.pop_front();
        check({tag, "_step_tick"}, step_tick, 1);
        check({tag, "_running"}, running, 1);
        check({tag, "_step"}, step, e.step);
        check({tag, "_trig"}, trig, e.trig);
    endtask

    task automatic model_edit();
        int idx;
        idx = -1;
        for (int v = 3; v >= 0; v--) if (voice_sel[v]) idx = v;
        if (idx >= 0) mpat[idx][cursor] = ~mpat[idx][cursor];
    endtask

    // Press and release keys; returns 1ns after the edge on which the action lands.
    task automatic fire(input bit p, input bit e);
        @(negedge clk);
        if (p) play_key = 1'b0;
        if (e) edit_key = 1'b0;
        repeat (3) @(negedge clk);
        play_key = 1'b1;
        edit_key = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (p) begin
            if (!mrun) begin
                mrun  = 1'b1;
                mstep = 4'd0;
                push_exp(4'd0);
            end else begin
                mrun  = 1'b0;
                mstep = 4'd0;
            end
        end
        if (e) model_edit();
        if (p && mrun) check_ev("start");
        if (p && !mrun) begin
            check("stop_running", running, 0);
            check("stop_step", step, 0);
            check("stop_trig", trig, 0);
            check("stop_step_tick", step_tick, 0);
        end
    endtask

    // Walk n step boundaries, checking quiet cycles in between.
    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 1; c < ST; c++) begin
                @(posedge clk);
                #1;
                check("quiet", {step_tick, trig}, 5'b0);
            end
            @(posedge clk);
            #1;
            mstep = mstep + 4'd1;
            push_exp(mstep);
            check_ev("step");
        end
    endtask

    // Called just after a step edge; lands an edit release exactly on the next step edge.
    task automatic edit_on_step();
        edit_key = 1'b0;
        @(posedge clk);
        #1;
        check("edit_quiet", {step_tick, trig}, 5'b0);
        @(negedge clk);
        edit_key = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("edit_quiet", {step_tick, trig}, 5'b0);
        end
        @(posedge clk);
        #1;
        mstep = mstep + 4'd1;
        push_exp(mstep);
        model_edit();
        check_ev("edit_step");
    endtask

    initial begin
        for (int v = 0; v < 4; v++) mpat[v] = 16'h0000;
        mrun  = 1'b0;
        mstep = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_running", running, 0);
        check("rst_step", step, 0);
        check("rst_trig", trig, 0);
        check("rst_step_tick", step_tick, 0);
        check("rst_view", pattern_view, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Holding play does nothing until release
        @(negedge clk);
        play_key = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_running", running, 0);
        check("hold_step_tick", step_tick, 0);
        play_key = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mrun  = 1'b1;
        mstep = 4'd0;
        push_exp(4'd0);
        check_ev("hold_start");
        fire(1'b1, 1'b0);

        // Pattern entry
        voice_sel = 4'b0001;
        cursor = 4'd0;
        fire(1'b0, 1'b1);
        cursor = 4'd4;
        fire(1'b0, 1'b1);
        check("view_kick", pattern_view, 16'h0011);
        voice_sel = 4'b0010;
        #1;
        check("view_snare_empty", pattern_view, 16'h0000);
        voice_sel = 4'b0000;
        fire(1'b0, 1'b1);
        check("view_none", pattern_view, 16'h0000);
        voice_sel = 4'b0001;
        #1;
        check("view_kick_kept", pattern_view, 16'h0011);
        voice_sel = 4'b0010;
        cursor = 4'd4;
        fire(1'b0, 1'b1);
        check("view_snare", pattern_view, 16'h0010);
        voice_sel = 4'b0011;
        #1;
        check("view_multi", pattern_view, 16'h0011);

        // Play a full lap plus wrap
        voice_sel = 4'b0001;
        fire(1'b1, 1'b0);
        check("start_trig_const", trig, 4'b0001);
        advance(16);
        check("wrap_trig_const", trig, 4'b0001);
        advance(2);

        // Stop mid-step, stay quiet, restart
        @(posedge clk);
        fire(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("stopped_quiet", {running, step_tick, trig, step}, 10'b0);
        end
        fire(1'b1, 1'b0);

        // Edit kick at step 1 exactly on the step-1 edge
        voice_sel = 4'b0001;
        cursor = 4'd1;
        edit_on_step();
        check("edit_old_trig", trig, 4'b0000);
        advance(16);
        check("edit_new_trig", trig, 4'b0001);

        // Simultaneous play and edit from STOP
        fire(1'b1, 1'b0);
        cursor = 4'd0;
        fire(1'b1, 1'b1);
        check("sim_pre_edit_trig", trig, 4'b0001);
        check("sim_view", pattern_view, mpat[0]);
        advance(16);

        // Asynchronous reset mid-step
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_running", running, 0);
        check("arst_step", step, 0);
        check("arst_trig", trig, 0);
        check("arst_step_tick", step_tick, 0);
        check("arst_view", pattern_view, 16'h0000);
        for (int v = 0; v < 4; v++) mpat[v] = 16'h0000;
        mrun  = 1'b0;
        mstep = 4'd0;
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int v = 0; v < 4; v++) begin
            voice_sel = 4'b0001 << v;
            #1;
            check("arst_pattern_cleared", pattern_view, 16'h0000);
        end
        voice_sel = 4'b0001;
        fire(1'b1, 1'b0);
        check("arst_restart_trig", trig, 4'b0000);
        advance(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
